fpga_ce_gen: RTL and testbench
==============================

# fpga_ce_gen

Programmable clock-enable strobe generator that sits directly upstream of the `fpga_dffer` register cells and drives their `E_i` inputs. It emits single-cycle enable pulses every `div+1` clock cycles, either periodically or as a one-shot, under a valid/ready configuration handshake and start/stop control. It lets a bank of enable-gated flops run at a divided rate without a derived clock.

## Interface
- `WIDTH`, default 8: width of the divider value and of the strobe counter.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `reset_i`  in  1: reset, synchronous, active-high.
- `cfg_valid_i`  in  1: a configuration word is offered.
- `cfg_ready_o`  out  1: configuration is accepted this cycle. Combinational, equal to (state == IDLE).
- `cfg_div_i`  in  WIDTH: divider value N; the strobe period is N+1 cycles.
- `cfg_mode_i`  in  1: 0 = periodic, 1 = one-shot; captured with `cfg_div_i`.
- `start_i`  in  1: start request, sampled in IDLE only.
- `stop_i`  in  1: stop request, sampled in RUN; has priority over everything except reset.
- `E_o`  out  1: registered enable strobe, high for exactly one cycle per period.
- `busy_o`  out  1: registered, equal to (state == RUN).
- `count_o`  out  WIDTH: registered count of strobes since the last accepted start; wraps from 2^WIDTH-1 to 0.

## Operation
- States: IDLE, RUN.
- Internal registers: `div_q` (WIDTH), `mode_q` (1), `cnt_q` (WIDTH).
- Config handshake: when `cfg_valid_i && cfg_ready_o` at an edge, `div_q <= cfg_div_i` and `mode_q <= cfg_mode_i`. In RUN, `cfg_ready_o` = 0, so the offer must be held by the sender and no register changes.
- IDLE, `start_i` = 1, `stop_i` = 0:
  - state goes to RUN.
  - `cnt_q` loads the effective divider. If a config handshake happens in the same cycle, the new `cfg_div_i`/`cfg_mode_i` are used for this run.
  - `count_o` clears to 0.
- IDLE, `start_i` and `stop_i` both 1: stop wins; stay in IDLE with nothing loaded except the config, if handshaken.
- RUN, `stop_i` = 1: go to IDLE at this edge. `E_o` is 0 after this edge even if `cnt_q` == 0.
- RUN, `cnt_q` != 0: `cnt_q` decrements by 1.
- RUN, `cnt_q` == 0 (no stop): `E_o` goes to 1 for the following cycle, and `count_o` increments modulo 2^WIDTH.
  - Periodic mode: `cnt_q` reloads from `div_q`.
  - One-shot mode: state goes to IDLE.
- RUN, `start_i`: ignored.
- N = 0: a strobe every cycle while in RUN, so `E_o` is continuously high in periodic mode.
- `E_o` is 0 in every cycle not listed above.

## Timing
- Reset (edge with `reset_i` = 1):
  - state = IDLE; `div_q` = 0, `mode_q` = 0, `cnt_q` = 0.
  - `E_o` = 0, `busy_o` = 0, `count_o` = 0, `cfg_ready_o` = 1.
  - Reset mid-run aborts immediately; a pending strobe is not emitted.
- With start accepted at edge k and divider N:
  - `busy_o` = 1 after edge k.
  - The first `E_o` pulse occupies the cycle after edge k+N+1.
  - Periodic mode: later pulses follow after edges k+2(N+1), k+3(N+1), and so on.
  - One-shot mode: `busy_o` falls after the same edge that raises `E_o`, and `cfg_ready_o` rises in that cycle.
- Start-to-first-strobe latency is therefore N+1 cycles; the strobe period is exactly N+1 cycles.
- `count_o` updates on the same edge that raises `E_o`.
- A restart is possible on the cycle immediately after one-shot completion or after a stop. There are no dead cycles.

## Test plan
- Reset, then idle: after `reset_i` is held for 2 cycles, `E_o`/`busy_o`/`count_o` = 0 and `cfg_ready_o` = 1. With `start_i` held at 0 for 20 cycles, no strobe appears.
- Periodic N = 3: config (3, 0), start at edge k. `E_o` pulses after edges k+4, k+8, k+12. `count_o` reads 1, 2, 3. Each pulse is 1 cycle wide.
- One-shot N = 2 plus restart: one pulse after edge k+3. `busy_o` = 0 and `cfg_ready_o` = 1 in the same cycle. A start on the next cycle gives the next pulse 3 cycles later.
- N = 0 and wrap: periodic with N = 0 and `WIDTH` = 8. `E_o` stays high continuously. `count_o` goes 255 → 0 after 256 strobes.
- Stop priority: periodic N = 1, with `stop_i` asserted in the cycle where `cnt_q` == 0. No pulse is emitted, state goes to IDLE, and `count_o` is unchanged. `start_i` and `stop_i` together in IDLE leave `busy_o` at 0.
- Config while running and reset mid-run:
  - `cfg_valid_i` held during RUN: `cfg_ready_o` stays 0 and the period is unchanged. The config is accepted on the first IDLE cycle.
  - `reset_i` pulsed 1 cycle before an expected strobe: no strobe, all outputs 0.

Source files
------------

// File: rtl/fpga_ce_gen.sv
// fpga_ce_gen: programmable clock-enable strobe generator.
// Emits a one-cycle E_o pulse every div+1 cycles, periodic or one-shot, so that
// a bank of enable-gated flops can run at a divided rate without a derived clock.
module fpga_ce_gen #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [WIDTH-1:0] cfg_div_i,
   input  logic             cfg_mode_i,
   input  logic             start_i,
   input  logic             stop_i,
   output logic             E_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             e_q, e_d;
   logic             cfg_take;
   logic             cnt_zero;

   assign cfg_take = cfg_valid_i && cfg_ready_o;
   assign cnt_zero = (cnt_q == '0);

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: stop beats start in IDLE and beats the strobe in RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_i && !stop_i) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (stop_i) begin
               state_d = StIdle;
            end else if (cnt_zero && mode_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      cfg_ready_o = (state_q == StIdle);
      busy_o      = (state_q == StRun);
   end

   // Datapath next-state: config capture, down-counter, strobe and strobe count.
   always_comb begin
      // A config accepted on the start edge takes effect for that very run.
      div_d   = cfg_take ? cfg_div_i  : div_q;
      mode_d  = cfg_take ? cfg_mode_i : mode_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      e_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i && !stop_i) begin
               cnt_d   = div_d;
               count_d = '0;
            end
         end
         StRun: begin
            if (!stop_i) begin
               if (!cnt_zero) begin
                  cnt_d = cnt_q - One;
               end else begin
                  e_d     = 1'b1;
                  count_d = count_q + One;
                  if (!mode_q) begin
                     cnt_d = div_q;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_q   <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         count_q <= '0;
         e_q     <= 1'b0;
      end else begin
         div_q   <= div_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         e_q     <= e_d;
      end
   end

   assign E_o     = e_q;
   assign count_o = count_q;

endmodule

// File: tb/tb_fpga_ce_gen.sv
// Testbench for fpga_ce_gen: directed scenarios plus randomized traffic, all
// checked against an arithmetic model (strobe when (t - start_edge) % (N+1) == 0).
module tb_fpga_ce_gen;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_div = '0;
   logic         cfg_mode = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         cfg_ready;
   logic         e;
   logic         busy;
   logic [W-1:0] count;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int     t = 0;
   bit     m_run = 0;
   int     m_k = 0;
   int     m_n = 0;
   bit     m_mode = 0;
   int     m_div = 0;
   bit     m_modecfg = 0;
   int     m_count = 0;
   bit     exp_e = 0;
   logic [W-1:0] exp_cnt;

   always #5 clk = ~clk;

   fpga_ce_gen #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_div_i   (cfg_div),
      .cfg_mode_i  (cfg_mode),
      .start_i     (start),
      .stop_i      (stop),
      .E_o         (e),
      .busy_o      (busy),
      .count_o     (count)
   );

   // Advance one clock edge and update the model with the inputs seen at that edge.
   task automatic tick();
      @(posedge clk);
      t++;
      exp_e = 0;
      if (reset) begin
         m_run = 0; m_div = 0; m_modecfg = 0; m_count = 0;
      end else if (!m_run) begin
         if (cfg_valid) begin
            m_div = int'(cfg_div);
            m_modecfg = cfg_mode;
         end
         if (start && !stop) begin
            m_run = 1; m_k = t; m_n = m_div; m_mode = m_modecfg; m_count = 0;
         end
      end else if (stop) begin
         m_run = 0;
      end else if ((t - m_k) % (m_n + 1) == 0) begin
         exp_e = 1;
         m_count = (m_count + 1) % 256;
         if (m_mode) m_run = 0;
      end
      exp_cnt = m_count[W-1:0];
      #1;
   endtask

   task automatic set_in(bit v, int d, bit md, bit st, bit sp);
      cfg_valid = v; cfg_div = W'(d); cfg_mode = md; start = st; stop = sp;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0);
      tick(); tick();
      reset = 1'b0;
      checks++;
      if (e !== 1'b0 || busy !== 1'b0 || count !== '0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: E=%b busy=%b count=%0d ready=%b, want 0 0 0 1",
                  e, busy, count, cfg_ready);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (e !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_strobe cyc %0d: E=%b busy=%b, want 0 0", i, e, busy);
         end
      end
   endtask

   task automatic test_periodic();
      set_in(1, 3, 0, 1, 0);
      tick();
      set_in(0, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         tick();
         checks++;
         if (e !== exp_e || busy !== 1'b1 || count !== exp_cnt) begin
            errors++;
            $display("FAIL periodic_model i=%0d: E=%b busy=%b count=%0d, want %b 1 %0d",
                     i, e, busy, count, exp_e, exp_cnt);
         end
         checks++;
         if (e !== (i % 4 == 0) || count !== W'(i / 4)) begin
            errors++;
            $display("FAIL periodic_n3 i=%0d: E=%b count=%0d, want %b %0d",
                     i, e, count, (i % 4 == 0), i / 4);
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_oneshot();
      set_in(1, 2, 1, 1, 0);
      tick();
      set_in(0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (e !== (i == 3) || busy !== (i != 3) || cfg_ready !== (i == 3) || count !== exp_cnt) begin
            errors++;
            $display("FAIL oneshot i=%0d: E=%b busy=%b ready=%b count=%0d, want %b %b %b %0d",
                     i, e, busy, cfg_ready, count, (i == 3), (i != 3), (i == 3), exp_cnt);
         end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (e !== (i == 3) || e !== exp_e || busy !== m_run) begin
            errors++;
            $display("FAIL oneshot_restart i=%0d: E=%b busy=%b, want %b %b",
                     i, e, busy, (i == 3), m_run);
         end
      end
   endtask

   task automatic test_n0_wrap();
      set_in(1, 0, 0, 1, 0);
      tick();
      set_in(0, 0, 0, 0, 0);
      for (int i = 1; i <= 260; i++) begin
         tick();
         checks++;
         if (e !== 1'b1 || count !== W'(i % 256) || count !== exp_cnt) begin
            errors++;
            $display("FAIL n0_wrap i=%0d: E=%b count=%0d, want 1 %0d", i, e, count, i % 256);
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_stop_priority();
      set_in(1, 1, 0, 1, 0);
      tick();
      set_in(0, 0, 0, 0, 0);
      tick(); tick(); tick();
      checks++;
      if (count !== 8'd1 || e !== 1'b0) begin
         errors++;
         $display("FAIL stop_pre: count=%0d E=%b, want 1 0", count, e);
      end
      stop = 1'b1;
      tick();
      checks++;
      if (e !== 1'b0 || busy !== 1'b0 || count !== 8'd1 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL stop_at_zero: E=%b busy=%b count=%0d ready=%b, want 0 0 1 1",
                  e, busy, count, cfg_ready);
      end
      start = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || e !== 1'b0 || busy !== m_run) begin
         errors++;
         $display("FAIL start_stop_idle: busy=%b E=%b, want 0 0", busy, e);
      end
      set_in(0, 0, 0, 0, 0);
   endtask

   task automatic test_cfg_during_run();
      set_in(1, 3, 0, 1, 0);
      tick();
      set_in(1, 7, 1, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if (cfg_ready !== 1'b0 || e !== (i % 4 == 0) || e !== exp_e) begin
            errors++;
            $display("FAIL cfg_hold_run i=%0d: ready=%b E=%b, want 0 %b",
                     i, cfg_ready, e, (i % 4 == 0));
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();  // first IDLE cycle: held offer is accepted here
      cfg_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if (e !== (i == 8) || busy !== (i < 8) || e !== exp_e) begin
            errors++;
            $display("FAIL cfg_after_run i=%0d: E=%b busy=%b, want %b %b",
                     i, e, busy, (i == 8), (i < 8));
         end
      end
   endtask

   task automatic test_reset_midrun();
      set_in(1, 4, 0, 1, 0);
      tick();
      set_in(0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (e !== 1'b0 || busy !== 1'b0 || count !== '0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_midrun: E=%b busy=%b count=%0d ready=%b, want 0 0 0 1",
                  e, busy, count, cfg_ready);
      end
      tick();
      checks++;
      if (e !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_midrun_after: E=%b busy=%b, want 0 0", e, busy);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         cfg_valid = $urandom_range(0, 1) == 1;
         cfg_div   = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
         cfg_mode  = $urandom_range(0, 2) == 0;
         start     = $urandom_range(0, 2) == 0;
         stop      = ($urandom_range(0, 29) == 0);
         tick();
         checks++;
         if (e !== exp_e || busy !== m_run || cfg_ready !== !m_run || count !== exp_cnt) begin
            errors++;
            $display("FAIL random t=%0d: E=%b busy=%b ready=%b count=%0d, want %b %b %b %0d",
                     t, e, busy, cfg_ready, count, exp_e, m_run, !m_run, exp_cnt);
         end
      end
      set_in(0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_oneshot();
      test_n0_wrap();
      test_stop_priority();
      test_cfg_during_run();
      test_reset_midrun();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
